pipe_height_gen: RTL and testbench
==================================

# pipe_height_gen

Parametrised, sequential generator of pipe-obstacle gap coordinates for the Flappy playfield. On each request it selects an entry from an internal height table, either round-robin or pseudo-random, and limits the step from the previous pipe. It then returns the gap's top and bottom Y coordinates with a one-cycle valid strobe. The obstacle logic uses it whenever a pipe respawns at the right screen edge.

## Interface
- Y_W, 10, width of Y coordinates (pixels)
- DEPTH, 4, table entries; power of two, ≥2; IDX_W = clog2(DEPTH)
- Y_MIN, 100, height of entry 0
- Y_STEP, 50, increment per entry: entry[i] = Y_MIN + i*Y_STEP
- GAP, 120, vertical gap size; y_bot = y_top + GAP
- SCREEN_H, 480, elaboration check: Y_MIN+(DEPTH-1)*Y_STEP+GAP ≤ SCREEN_H, else $error
- MAX_DELTA, 100, max |y_top(n) − y_top(n−1)|; 0 disables clamping
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request the next pipe; sampled only in IDLE
- seed_ld  in  1  load LFSR from seed (random mode only; ignored otherwise)
- seed  in  16  LFSR seed; 0 is replaced by 16'hACE1
- y_top  out  Y_W  top edge of gap, registered
- y_bot  out  Y_W  bottom edge of gap, registered
- valid  out  1  one-cycle strobe; y_top/y_bot updated in the same cycle
- busy  out  1  high while the request is in LOOKUP or CLAMP

## Operation
- FSM has three states.
  - IDLE: on req → LOOKUP, and the index is latched.
  - LOOKUP: entry[idx] is registered → CLAMP.
  - CLAMP: the clamped value is written to y_top/y_bot/prev, valid=1 → IDLE.
- Index source without the macro: a round-robin counter. It resets to 0, is used at the req edge, then increments mod DEPTH.
- LFSR: 16-bit, shift left, bit0 ← b15^b13^b12^b10. It is free-running every clock, including in non-random builds.
  - seed_ld has priority over advancing.
  - The reset value is 16'hACE1.
- Clamp, computed in Y_W+1 bits to avoid overflow:
  - if e > prev+MAX_DELTA, use prev+MAX_DELTA;
  - else if e+MAX_DELTA < prev, use prev−MAX_DELTA;
  - else use e.
- prev is the last output y_top; its reset value is Y_MIN.
- y_bot = y_top + GAP. It never exceeds SCREEN_H, by the elaboration check and because the clamp never leaves the range [Y_MIN, max entry].
- Outputs hold their values between valid pulses.

## Timing
- Reset values: y_top=Y_MIN, y_bot=Y_MIN+GAP, valid=0, busy=0, state=IDLE, counter=0, LFSR=16'hACE1, prev=Y_MIN.
- Latency: req sampled high at edge k → busy high after edges k and k+1 → y_top/y_bot/valid updated at edge k+2.
  - valid is high for exactly one cycle and falls at k+3.
  - busy falls at k+2.
- Throughput: a req seen at edge k+3 is accepted, giving one result per 3 cycles max.
- req while busy is ignored (it is not queued). req held high continuously yields a result every 3 cycles.
- seed_ld and req in the same cycle: the index comes from the pre-load LFSR value, and the load takes effect at that edge.
- Round-robin wrap: index DEPTH−1 → 0. The clamp then applies as normal.
- Reset asserted mid-request (LOOKUP/CLAMP): everything returns to reset values immediately. No valid is issued, and a later req starts fresh.

## Configuration
- PIPE_RANDOM_EN defined: index = LFSR[IDX_W-1:0], sampled at the accepting req edge; seed_ld/seed are functional.
- Not defined: round-robin counter index; seed_ld/seed ignored; LFSR still runs but is unused.

## Test plan
- Reset: hold rst_n=0 → y_top=100, y_bot=220, valid=0, busy=0; release, idle 10 cycles → no valid.
- Round-robin with defaults, no macro, 8 spaced reqs:
  - y_top sequence 100,150,200,250,150,150,200,250;
  - the fifth value is clamped from 100 by MAX_DELTA=100.
- Latency/busy: req at edge k, held for 2 cycles:
  - valid only in cycle k+2..k+3, busy over k..k+2;
  - exactly one result, with no second request accepted during busy.
- MAX_DELTA=0, no macro, 5 reqs → 100,150,200,250,100; y_bot always y_top+120.
- PIPE_RANDOM_EN: seed_ld with seed=0 → LFSR=16'hACE1; req on the next edge → index 01 → y_top=150, y_bot=270, valid at +2.
- Reset mid-op: rst_n low one cycle after an accepted req → no valid pulse, outputs 100/220, next req produces y_top=100 (round-robin).

Source files
------------

// File: rtl/pipe_height_gen.sv
// -----------------------------------------------------------------------------
// pipe_height_gen
//
// Produces the gap coordinates for a respawning pipe obstacle. Each accepted
// request picks an entry from a linear height table (Y_MIN + i*Y_STEP). The
// entry is either the next one in round-robin order or the one named by the
// low bits of a free-running LFSR. The new top edge is limited to within
// MAX_DELTA of the previous pipe, and the top/bottom edges are returned with a
// one-cycle valid strobe.
//
// Build option: define PIPE_RANDOM_EN for LFSR-based selection. In that build
// seed_ld/seed reload the LFSR. Without it, selection is round-robin and
// seed_ld/seed are ignored.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   request the next pipe (sampled only when idle)
//   seed_ld  in   load LFSR from seed (random build only)
//   seed     in   LFSR seed; zero is replaced by 16'hACE1
//   y_top    out  top edge of the gap, registered
//   y_bot    out  bottom edge of the gap (y_top + GAP), registered
//   valid    out  one-cycle strobe, y_top/y_bot updated in the same cycle
//   busy     out  high while a request is in LOOKUP or CLAMP
// -----------------------------------------------------------------------------
module pipe_height_gen #(
  parameter int Y_W       = 10,
  parameter int DEPTH     = 4,
  parameter int Y_MIN     = 100,
  parameter int Y_STEP    = 50,
  parameter int GAP       = 120,
  parameter int SCREEN_H  = 480,
  parameter int MAX_DELTA = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           seed_ld,
  input  logic [15:0]    seed,
  output logic [Y_W-1:0] y_top,
  output logic [Y_W-1:0] y_bot,
  output logic           valid,
  output logic           busy
);

  localparam int             IDX_W    = $clog2(DEPTH);
  localparam logic [15:0]    LFSR_RST = 16'hACE1;
  localparam logic [Y_W-1:0] Y_MIN_W  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] GAP_W    = Y_W'(GAP);
  localparam logic [Y_W:0]   MD_X     = (Y_W+1)'(MAX_DELTA);

  // Elaboration-time sanity checks on the table geometry.
  if (Y_MIN + (DEPTH - 1) * Y_STEP + GAP > SCREEN_H) begin : g_screen_chk
    $error("pipe_height_gen: lowest gap bottom exceeds SCREEN_H");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("pipe_height_gen: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_CLAMP
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [Y_W-1:0]   entry_q, entry_d;
  logic [Y_W-1:0]   y_top_q, y_top_d;
  logic [Y_W-1:0]   y_bot_q, y_bot_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      lfsr_q, lfsr_d;
`ifndef PIPE_RANDOM_EN
  logic [IDX_W-1:0] cnt_q, cnt_d;
`endif

  // Clamp arithmetic is one bit wider than Y_W so prev + MAX_DELTA cannot wrap.
  // The previous pipe's top edge is simply the current y_top register.
  logic [Y_W:0]   e_x, p_x, hi_x, clamp_x;
  logic [Y_W-1:0] clamp_w;

  always_comb begin
    e_x  = {1'b0, entry_q};
    p_x  = {1'b0, y_top_q};
    hi_x = p_x + MD_X;
    if (MAX_DELTA != 0 && e_x > hi_x) begin
      clamp_x = hi_x;
    end else if (MAX_DELTA != 0 && (e_x + MD_X) < p_x) begin
      clamp_x = p_x - MD_X;
    end else begin
      clamp_x = e_x;
    end
    clamp_w = clamp_x[Y_W-1:0];
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    y_top_d = y_top_q;
    y_bot_d = y_bot_q;
    valid_d = 1'b0;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`ifdef PIPE_RANDOM_EN
    // A load wins over advancing. The index below still sees the pre-load value.
    if (seed_ld) begin
      lfsr_d = (seed == 16'h0000) ? LFSR_RST : seed;
    end
`else
    cnt_d = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOOKUP;
`ifdef PIPE_RANDOM_EN
          idx_d = lfsr_q[IDX_W-1:0];
`else
          idx_d = cnt_q;
          cnt_d = cnt_q + IDX_W'(1);  // DEPTH is a power of two: wraps naturally
`endif
        end
      end
      S_LOOKUP: begin
        entry_d = Y_W'(Y_MIN + int'(idx_q) * Y_STEP);
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        y_top_d = clamp_w;
        y_bot_d = clamp_w + GAP_W;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      entry_q <= Y_MIN_W;
      y_top_q <= Y_MIN_W;
      y_bot_q <= Y_MIN_W + GAP_W;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      lfsr_q  <= LFSR_RST;
`ifndef PIPE_RANDOM_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      y_top_q <= y_top_d;
      y_bot_q <= y_bot_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      lfsr_q  <= lfsr_d;
`ifndef PIPE_RANDOM_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign y_top = y_top_q;
  assign y_bot = y_bot_q;
  assign valid = valid_q;
  assign busy  = busy_q;

  // The clamp never leaves [Y_MIN, max entry], so the carry bit is never
  // needed downstream. The seed inputs only matter in the random build.
  logic unused_sink;
`ifdef PIPE_RANDOM_EN
  assign unused_sink = clamp_x[Y_W];
`else
  assign unused_sink = ^{clamp_x[Y_W], seed_ld, seed};
`endif

endmodule

// File: tb/tb_pipe_height_gen.sv
module tb_pipe_height_gen;

  localparam int Y_W       = 10;
  localparam int DEPTH     = 4;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int Y_MIN     = 100;
  localparam int Y_STEP    = 50;
  localparam int GAP       = 120;
  localparam int SCREEN_H  = 480;
  localparam int MAX_DELTA = 100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req = 1'b0;
  logic           seed_ld = 1'b0;
  logic [15:0]    seed = 16'h0000;
  logic [Y_W-1:0] y_top_a, y_bot_a, y_top_b, y_bot_b;
  logic           valid_a, busy_a, valid_b, busy_b;

  always #5 clk = ~clk;

  // Instance a: default clamping. Instance b: clamping disabled.
  pipe_height_gen #(
    .Y_W(Y_W), .DEPTH(DEPTH), .Y_MIN(Y_MIN), .Y_STEP(Y_STEP), .GAP(GAP),
    .SCREEN_H(SCREEN_H), .MAX_DELTA(MAX_DELTA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_ld(seed_ld), .seed(seed),
    .y_top(y_top_a), .y_bot(y_bot_a), .valid(valid_a), .busy(busy_a)
  );

  pipe_height_gen #(
    .Y_W(Y_W), .DEPTH(DEPTH), .Y_MIN(Y_MIN), .Y_STEP(Y_STEP), .GAP(GAP),
    .SCREEN_H(SCREEN_H), .MAX_DELTA(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_ld(seed_ld), .seed(seed),
    .y_top(y_top_b), .y_bot(y_bot_b), .valid(valid_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_ref(input int e, input int p, input int md);
    if (md == 0)     return e;
    if (e - p > md)  return p + md;
    if (p - e > md)  return p - md;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference: a request is accepted when it arrives at
  // least three edges after the previous accepted one; its result appears two
  // edges later and busy covers the edges in between.
  // ---------------------------------------------------------------------------
  int          cyc, next_ok, due, rr, m_idx, m_e;
  bit          pend, exp_valid, exp_busy;
  int          pend_top[2], exp_top[2], prev_top[2];
  logic [15:0] lfsr_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; next_ok = 0; due = 0; rr = 0; pend = 0;
      exp_valid = 0; exp_busy = 0; lfsr_m = 16'hACE1;
      for (int k = 0; k < 2; k++) begin
        exp_top[k] = Y_MIN; prev_top[k] = Y_MIN; pend_top[k] = Y_MIN;
      end
    end else begin
      exp_valid = 0;
      if (pend && cyc == due) begin
        exp_top   = pend_top;
        exp_valid = 1;
        pend      = 0;
      end
      if (req && cyc >= next_ok) begin
`ifdef PIPE_RANDOM_EN
        m_idx = int'(lfsr_m) % DEPTH;
`else
        m_idx = rr;
        rr    = (rr + 1) % DEPTH;
`endif
        m_e         = Y_MIN + m_idx * Y_STEP;
        pend_top[0] = clamp_ref(m_e, prev_top[0], MAX_DELTA);
        pend_top[1] = clamp_ref(m_e, prev_top[1], 0);
        prev_top    = pend_top;
        due         = cyc + 2;
        next_ok     = cyc + 3;
        pend        = 1;
      end
      exp_busy = pend;
`ifdef PIPE_RANDOM_EN
      if (seed_ld) lfsr_m = (seed == 16'h0) ? 16'hACE1 : seed;
      else
`endif
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      cyc++;
    end
  end

  // Cycle monitor, sampled on the falling edge.
  bit mon_en = 0;
  int vcount = 0;
  int seq_a[$], seq_b[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_a", int'(valid_a), int'(exp_valid));
      check("busy_a",  int'(busy_a),  int'(exp_busy));
      check("y_top_a", int'(y_top_a), exp_top[0]);
      check("y_bot_a", int'(y_bot_a), exp_top[0] + GAP);
      check("valid_b", int'(valid_b), int'(exp_valid));
      check("busy_b",  int'(busy_b),  int'(exp_busy));
      check("y_top_b", int'(y_top_b), exp_top[1]);
      check("y_bot_b", int'(y_bot_b), exp_top[1] + GAP);
      if (valid_a) begin
        vcount++;
        seq_a.push_back(int'(y_top_a));
      end
      if (valid_b) seq_b.push_back(int'(y_top_b));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic one_req();
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(3);
  endtask

  int v0;
  int exp_rr[8];
  int exp_nc[5];

  initial begin
    exp_rr = '{100, 150, 200, 250, 150, 150, 200, 250};
    exp_nc = '{100, 150, 200, 250, 100};

    // Reset values while reset is held, then quiet idle after release.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    mon_en = 1;
    tick(3);
    check("rst_y_top", int'(y_top_a), 100);
    check("rst_y_bot", int'(y_bot_a), 220);
    check("rst_valid", int'(valid_a), 0);
    check("rst_busy",  int'(busy_a),  0);
    #2 rst_n = 1'b1;
    v0 = vcount;
    tick(10);
    check("idle_no_valid", vcount - v0, 0);

`ifdef PIPE_RANDOM_EN
    // A zero seed loads 16'hACE1, whose low bits select entry 1.
    seed_ld = 1'b1; seed = 16'h0000;
    tick(1);
    seed_ld = 1'b0; req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(1);
    check("seed_valid_early", int'(valid_a), 0);
    tick(1);
    check("seed_valid", int'(valid_a), 1);
    check("seed_y_top", int'(y_top_a), 150);
    check("seed_y_bot", int'(y_bot_a), 270);
    tick(2);
`else
    // Round-robin sequence from a fresh reset, clamped and unclamped.
    seq_a.delete();
    seq_b.delete();
    for (int i = 0; i < 8; i++) one_req();
    check("rr_count", seq_a.size(), 8);
    for (int i = 0; i < 8 && i < seq_a.size(); i++) check($sformatf("rr_seq[%0d]", i), seq_a[i], exp_rr[i]);
    for (int i = 0; i < 5 && i < seq_b.size(); i++) check($sformatf("nc_seq[%0d]", i), seq_b[i], exp_nc[i]);
`endif

    // Latency and busy window with req held for two cycles.
    tick(2);
    v0 = vcount;
    req = 1'b1;
    tick(1);
    check("lat_k_busy",   int'(busy_a),  1);
    check("lat_k_valid",  int'(valid_a), 0);
    tick(1);
    req = 1'b0;
    check("lat_k1_busy",  int'(busy_a),  1);
    check("lat_k1_valid", int'(valid_a), 0);
    tick(1);
    check("lat_k2_busy",  int'(busy_a),  0);
    check("lat_k2_valid", int'(valid_a), 1);
    tick(1);
    check("lat_k3_valid", int'(valid_a), 0);
    check("lat_k3_busy",  int'(busy_a),  0);
    tick(3);
    check("lat_one_result", vcount - v0, 1);

    // Reset one cycle into an accepted request: no result, clean restart.
    req = 1'b1;
    tick(1);
    req = 1'b0;
    v0 = vcount;
    #2 rst_n = 1'b0;
    tick(1);
    check("mid_rst_y_top", int'(y_top_a), 100);
    check("mid_rst_y_bot", int'(y_bot_a), 220);
    check("mid_rst_busy",  int'(busy_a),  0);
    #2 rst_n = 1'b1;
    tick(4);
    check("mid_rst_no_valid", vcount - v0, 0);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(2);
    check("mid_rst_restart_valid", int'(valid_a), 1);
`ifndef PIPE_RANDOM_EN
    check("mid_rst_restart_y_top", int'(y_top_a), 100);
`endif
    tick(2);

    // Randomized traffic, checked every cycle by the monitor.
    for (int i = 0; i < 400; i++) begin
      req     = ($urandom_range(0, 2) != 0);
      seed_ld = ($urandom_range(0, 9) == 0);
      seed    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        tick(1);
        #2 rst_n = 1'b1;
      end
      tick(1);
    end
    req = 1'b0;
    seed_ld = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
